// File: rtl/riscv_issue_decoder_pkg.sv
// Shared definitions for the issue-stage decoder: class bit positions, opcodes and
// the per-lane decode record passed from riscv_lane_decode to the grouping logic.
package riscv_issue_decoder_pkg;

  localparam int ISSUE_CLS_W      = 7;
  localparam int ISSUE_CLS_RD     = 0;
  localparam int ISSUE_CLS_ALU    = 1;
  localparam int ISSUE_CLS_LSU    = 2;
  localparam int ISSUE_CLS_BRANCH = 3;
  localparam int ISSUE_CLS_MUL    = 4;
  localparam int ISSUE_CLS_DIV    = 5;
  localparam int ISSUE_CLS_CSR    = 6;

  typedef enum logic [6:0] {
    OPC_LUI     = 7'b0110111,
    OPC_AUIPC   = 7'b0010111,
    OPC_JAL     = 7'b1101111,
    OPC_JALR    = 7'b1100111,
    OPC_BRANCH  = 7'b1100011,
    OPC_LOAD    = 7'b0000011,
    OPC_STORE   = 7'b0100011,
    OPC_OPIMM   = 7'b0010011,
    OPC_OP      = 7'b0110011,
    OPC_MISCMEM = 7'b0001111,
    OPC_SYSTEM  = 7'b1110011
  } opcode_e;

  // cls[ISSUE_CLS_RD] means "writes a register other than x0"
  typedef struct packed {
    logic [ISSUE_CLS_W-1:0] cls;
    logic [4:0]             rd;
    logic [4:0]             rs1;
    logic [4:0]             rs2;
    logic                   use_rs1;
    logic                   use_rs2;
    logic                   illegal;
  } lane_dec_t;

  function automatic logic [31:0] lane_pc(input logic [31:0] base, input int k);
    return base + 32'(4 * k);
  endfunction

endpackage

// File: rtl/riscv_issue_decoder_lane_decode.sv
// Combinational classifier for one instruction lane: unit class, register fields,
// which sources are actually read, and whether the encoding is unrecognised.
module riscv_lane_decode
  import riscv_issue_decoder_pkg::*;
#(
  parameter bit SUPPORT_MULDIV = 1'b1
) (
  input  logic [31:0] inst_i,
  output lane_dec_t   dec_o
);

  logic [2:0]             funct3;
  logic [6:0]             funct7;
  logic [ISSUE_CLS_W-1:0] cls;
  logic                   wr_rd;
  logic                   use1;
  logic                   use2;
  logic                   legal;

  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];

  always_comb begin
    cls   = '0;
    wr_rd = 1'b0;
    use1  = 1'b0;
    use2  = 1'b0;
    legal = 1'b1;
    case (inst_i[6:0])
      OPC_LUI, OPC_AUIPC: begin cls[ISSUE_CLS_ALU] = 1'b1; wr_rd = 1'b1; end
      OPC_JAL:            begin cls[ISSUE_CLS_BRANCH] = 1'b1; wr_rd = 1'b1; end
      OPC_JALR: begin
        legal = (funct3 == 3'b000);
        cls[ISSUE_CLS_BRANCH] = 1'b1; wr_rd = 1'b1; use1 = 1'b1;
      end
      OPC_BRANCH: begin
        legal = (funct3 != 3'b010) && (funct3 != 3'b011);
        cls[ISSUE_CLS_BRANCH] = 1'b1; use1 = 1'b1; use2 = 1'b1;
      end
      OPC_LOAD: begin
        legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        cls[ISSUE_CLS_LSU] = 1'b1; wr_rd = 1'b1; use1 = 1'b1;
      end
      OPC_STORE: begin
        legal = funct3 inside {3'b000, 3'b001, 3'b010};
        cls[ISSUE_CLS_LSU] = 1'b1; use1 = 1'b1; use2 = 1'b1;
      end
      OPC_OPIMM: begin
        if (funct3 == 3'b001) legal = (funct7 == 7'b0000000);
        if (funct3 == 3'b101) legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
        cls[ISSUE_CLS_ALU] = 1'b1; wr_rd = 1'b1; use1 = 1'b1;
      end
      OPC_OP: begin
        if (funct7 == 7'b0000001) begin
          // M-extension ops stay legal but are NOPs when the unit is absent
          if (SUPPORT_MULDIV) begin
            cls[funct3[2] ? ISSUE_CLS_DIV : ISSUE_CLS_MUL] = 1'b1;
            wr_rd = 1'b1; use1 = 1'b1; use2 = 1'b1;
          end
        end else begin
          legal = (funct7 == 7'b0000000) ||
                  ((funct7 == 7'b0100000) && (funct3 inside {3'b000, 3'b101}));
          cls[ISSUE_CLS_ALU] = 1'b1; wr_rd = 1'b1; use1 = 1'b1; use2 = 1'b1;
        end
      end
      OPC_MISCMEM: legal = funct3 inside {3'b000, 3'b001};
      OPC_SYSTEM: begin
        cls[ISSUE_CLS_CSR] = 1'b1;
        if (funct3 == 3'b000) begin
          legal = inst_i inside {32'h00000073, 32'h00100073, 32'h30200073, 32'h10500073};
        end else begin
          legal = (funct3 != 3'b100);
          wr_rd = 1'b1;
          use1  = !funct3[2];
        end
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      cls   = '0;
      wr_rd = 1'b0;
      use1  = 1'b0;
      use2  = 1'b0;
    end
    cls[ISSUE_CLS_RD] = wr_rd && (inst_i[11:7] != 5'd0);
  end

  always_comb begin
    dec_o         = '0;
    dec_o.cls     = cls;
    dec_o.rd      = inst_i[11:7];
    dec_o.rs1     = inst_i[19:15];
    dec_o.rs2     = inst_i[24:20];
    dec_o.use_rs1 = use1;
    dec_o.use_rs2 = use2;
    dec_o.illegal = !legal;
  end

endmodule

// File: rtl/riscv_issue_decoder.sv
// Issue-stage decoder: buffers one fetch bundle and releases it as hazard-free issue groups.
// Optional feature macro RISCV_ILLEGAL_TRAP_EN: unknown encodings flagged illegal and issued alone.
//  state    | meaning
//  ST_EMPTY | no lanes remaining, buffer free for a new bundle
//  ST_HOLD  | remaining lanes held, current group presented on issue_*
module riscv_issue_decoder
  import riscv_issue_decoder_pkg::*;
#(
  parameter int ISSUE_WIDTH    = 2,
  parameter bit SUPPORT_MULDIV = 1'b1
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               flush_i,
  input  logic                               fetch_valid_i,
  output logic                               fetch_ready_o,
  input  logic [32*ISSUE_WIDTH-1:0]          fetch_inst_i,
  input  logic [31:0]                        fetch_pc_i,
  input  logic [ISSUE_WIDTH-1:0]             fetch_mask_i,
  output logic                               issue_valid_o,
  input  logic                               issue_ready_i,
  output logic [ISSUE_WIDTH-1:0]             issue_mask_o,
  output logic [32*ISSUE_WIDTH-1:0]          issue_inst_o,
  output logic [32*ISSUE_WIDTH-1:0]          issue_pc_o,
  output logic [ISSUE_CLS_W*ISSUE_WIDTH-1:0] issue_class_o,
  output logic [ISSUE_WIDTH-1:0]             issue_illegal_o
);

  localparam int W = ISSUE_WIDTH;
`ifdef RISCV_ILLEGAL_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  typedef enum logic {ST_EMPTY, ST_HOLD} state_e;

  state_e                   state_q, state_d;
  logic [32*W-1:0]          inst_q, inst_d;
  logic [32*W-1:0]          pc_q, pc_d;
  logic [W-1:0]             rem_q, rem_d, rem_after;
  logic [W-1:0]             grp_q, grp_d;
  logic [ISSUE_CLS_W*W-1:0] cls_q, cls_d;
  logic [W-1:0]             ill_q, ill_d;
  logic                     fire, accept;
  lane_dec_t                dec [W];

  for (genvar k = 0; k < W; k++) begin : g_lane
    riscv_lane_decode #(.SUPPORT_MULDIV(SUPPORT_MULDIV)) u_dec (
      .inst_i(inst_d[32*k +: 32]),
      .dec_o (dec[k])
    );
  end

  assign fire      = (state_q == ST_HOLD) && issue_ready_i;
  assign rem_after = fire ? (rem_q & ~grp_q) : rem_q;
  assign accept    = fetch_valid_i && fetch_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      inst_q  <= '0;
      pc_q    <= '0;
      rem_q   <= '0;
      grp_q   <= '0;
      cls_q   <= '0;
      ill_q   <= '0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      rem_q   <= rem_d;
      grp_q   <= grp_d;
      cls_q   <= cls_d;
      ill_q   <= ill_d;
    end
  end

  always_comb begin
    inst_d = inst_q;
    pc_d   = pc_q;
    rem_d  = rem_after;
    if (accept) begin
      inst_d = fetch_inst_i;
      rem_d  = fetch_mask_i;
      for (int k = 0; k < W; k++) pc_d[32*k +: 32] = lane_pc(fetch_pc_i, k);
    end
    if (flush_i) rem_d = '0;
    state_d = (rem_d == '0) ? ST_EMPTY : ST_HOLD;
  end

  // Next group is formed from the post-edge remaining mask so a fire never leaves a bubble
  always_comb begin
    logic [31:0] rd_busy;
    logic        stop, first, have_lsu, have_md, have_br, trap, conflict;
    grp_d    = '0;
    cls_d    = '0;
    ill_d    = '0;
    rd_busy  = '0;
    stop     = 1'b0;
    first    = 1'b1;
    have_lsu = 1'b0;
    have_md  = 1'b0;
    have_br  = 1'b0;
    for (int k = 0; k < W; k++) begin
      trap = TrapEn && dec[k].illegal;
      cls_d[ISSUE_CLS_W*k +: ISSUE_CLS_W] = dec[k].cls;
      ill_d[k] = trap;
      conflict = (dec[k].use_rs1 && rd_busy[dec[k].rs1]) ||
                 (dec[k].use_rs2 && rd_busy[dec[k].rs2]) ||
                 (dec[k].cls[ISSUE_CLS_RD] && rd_busy[dec[k].rd]) ||
                 (dec[k].cls[ISSUE_CLS_LSU] && have_lsu) ||
                 ((dec[k].cls[ISSUE_CLS_MUL] || dec[k].cls[ISSUE_CLS_DIV]) && have_md) ||
                 dec[k].cls[ISSUE_CLS_CSR] || trap || have_br;
      if (rem_d[k] && !stop) begin
        if (!first && conflict) begin
          stop = 1'b1;
        end else begin
          grp_d[k] = 1'b1;
          if (dec[k].cls[ISSUE_CLS_RD]) rd_busy[dec[k].rd] = 1'b1;
          have_lsu = have_lsu || dec[k].cls[ISSUE_CLS_LSU];
          have_md  = have_md || dec[k].cls[ISSUE_CLS_MUL] || dec[k].cls[ISSUE_CLS_DIV];
          have_br  = have_br || dec[k].cls[ISSUE_CLS_BRANCH];
          if (first && (dec[k].cls[ISSUE_CLS_CSR] || trap)) stop = 1'b1;
          first = 1'b0;
        end
      end
    end
  end

  always_comb begin
    fetch_ready_o   = !rst_i && !flush_i &&
                      ((state_q == ST_EMPTY) || (fire && (rem_after == '0)));
    issue_valid_o   = (state_q == ST_HOLD);
    issue_mask_o    = grp_q;
    issue_inst_o    = inst_q;
    issue_pc_o      = pc_q;
    issue_class_o   = cls_q;
    issue_illegal_o = ill_q;
  end

endmodule

// File: tb/tb_riscv_issue_decoder.sv
// Bench for riscv_issue_decoder (4 lanes): directed scenarios plus random traffic,
// every cycle compared against a format-level reference model of the grouping rules.
module tb_riscv_issue_decoder;

  localparam int W      = 4;
  localparam bit MULDIV = 1'b1;
`ifdef RISCV_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic              clk_i = 1'b0;
  logic              rst_i, flush_i, fetch_valid_i, fetch_ready_o;
  logic [32*W-1:0]   fetch_inst_i;
  logic [31:0]       fetch_pc_i;
  logic [W-1:0]      fetch_mask_i;
  logic              issue_valid_o, issue_ready_i;
  logic [W-1:0]      issue_mask_o, issue_illegal_o;
  logic [32*W-1:0]   issue_inst_o, issue_pc_o;
  logic [7*W-1:0]    issue_class_o;

  riscv_issue_decoder #(.ISSUE_WIDTH(W), .SUPPORT_MULDIV(MULDIV)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .fetch_valid_i(fetch_valid_i), .fetch_ready_o(fetch_ready_o),
    .fetch_inst_i(fetch_inst_i), .fetch_pc_i(fetch_pc_i), .fetch_mask_i(fetch_mask_i),
    .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
    .issue_mask_o(issue_mask_o), .issue_inst_o(issue_inst_o), .issue_pc_o(issue_pc_o),
    .issue_class_o(issue_class_o), .issue_illegal_o(issue_illegal_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [6:0] cls;
    logic [4:0] rd, rs1, rs2;
    bit         r1, r2, ill;
  } mdec_t;

  logic [31:0]  m_inst [W];
  logic [31:0]  m_pc;
  logic [W-1:0] m_rem, m_grp;
  logic [W-1:0] last_mask;
  logic         last_frdy;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Format-driven reference decode: unit from the opcode, register usage from the format letter
  function automatic mdec_t mdecode(input logic [31:0] i);
    mdec_t d;
    byte   fmt;
    int    unit;
    bit    legal, wr;
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = i[14:12]; f7 = i[31:25];
    d = '{cls: 7'd0, rd: i[11:7], rs1: i[19:15], rs2: i[24:20], r1: 0, r2: 0, ill: 0};
    fmt = "N"; unit = 0; legal = 1;
    case (i[6:0])
      7'h37, 7'h17: begin fmt = "U"; unit = 1; end
      7'h6F: begin fmt = "J"; unit = 3; end
      7'h67: begin fmt = "I"; unit = 3; legal = (f3 == 0); end
      7'h63: begin fmt = "B"; unit = 3; legal = (f3 != 2) && (f3 != 3); end
      7'h03: begin fmt = "I"; unit = 2; legal = (f3 != 3) && (f3 < 6); end
      7'h23: begin fmt = "S"; unit = 2; legal = (f3 <= 2); end
      7'h13: begin
        fmt = "I"; unit = 1;
        if (f3 == 1) legal = (f7 == 0);
        if (f3 == 5) legal = (f7 == 0) || (f7 == 7'h20);
      end
      7'h33: begin
        fmt = "R";
        if (f7 == 1) unit = f3[2] ? 5 : 4;
        else begin unit = 1; legal = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5)); end
      end
      7'h0F: legal = (f3 <= 1);
      7'h73: begin
        unit = 6;
        if (f3 == 0) legal = (i == 32'h00000073) || (i == 32'h00100073) ||
                             (i == 32'h30200073) || (i == 32'h10500073);
        else begin legal = (f3 != 4); fmt = f3[2] ? "Z" : "I"; end
      end
      default: legal = 0;
    endcase
    d.ill = !legal;
    if (legal && !((unit == 4 || unit == 5) && !MULDIV)) begin
      wr   = (fmt == "U") || (fmt == "J") || (fmt == "I") || (fmt == "R") || (fmt == "Z");
      d.r1 = (fmt == "I") || (fmt == "S") || (fmt == "B") || (fmt == "R");
      d.r2 = (fmt == "S") || (fmt == "B") || (fmt == "R");
      if (unit != 0) d.cls[unit] = 1'b1;
      d.cls[0] = wr && (d.rd != 0);
    end
    return d;
  endfunction

  // Pairwise check of each candidate against every lane already placed in the group
  function automatic logic [W-1:0] model_group(input logic [W-1:0] rem);
    logic [W-1:0] g;
    int           mem[$];
    mdec_t        d, e;
    bit           ok;
    g = '0;
    for (int k = 0; k < W; k++) begin
      if (!rem[k]) continue;
      d = mdecode(m_inst[k]);
      if (mem.size() == 0) begin
        g[k] = 1'b1; mem.push_back(k);
        if (d.cls[6] || (d.ill && TRAP)) break;
        continue;
      end
      ok = !(d.cls[6] || (d.ill && TRAP));
      foreach (mem[j]) begin
        e = mdecode(m_inst[mem[j]]);
        if (e.cls[0] && ((d.r1 && e.rd == d.rs1) || (d.r2 && e.rd == d.rs2) ||
                         (d.cls[0] && e.rd == d.rd))) ok = 0;
        if (e.cls[2] && d.cls[2]) ok = 0;
        if ((e.cls[4] || e.cls[5]) && (d.cls[4] || d.cls[5])) ok = 0;
        if (e.cls[3] || e.cls[6]) ok = 0;
      end
      if (!ok) break;
      g[k] = 1'b1; mem.push_back(k);
    end
    return g;
  endfunction

  // Called at a negedge with inputs already driven; returns at the next negedge
  task automatic step();
    logic  exp_frdy;
    mdec_t d;
    #1;
    exp_frdy = !rst_i && !flush_i &&
               ((m_rem == 0) || (issue_ready_i && ((m_rem & ~m_grp) == 0)));
    chk("fetch_ready", fetch_ready_o, exp_frdy);
    chk("issue_valid", issue_valid_o, m_rem != 0);
    chk("issue_mask", issue_mask_o, m_grp);
    if (m_rem != 0) begin
      for (int k = 0; k < W; k++) begin
        if (m_grp[k]) begin
          d = mdecode(m_inst[k]);
          chk($sformatf("inst_l%0d", k), issue_inst_o[32*k +: 32], m_inst[k]);
          chk($sformatf("pc_l%0d", k), issue_pc_o[32*k +: 32], m_pc + 32'(4*k));
          chk($sformatf("class_l%0d", k), issue_class_o[7*k +: 7], d.cls);
          chk($sformatf("illegal_l%0d", k), issue_illegal_o[k], d.ill && TRAP);
        end
      end
    end
    last_mask = issue_mask_o;
    last_frdy = fetch_ready_o;
    @(posedge clk_i);
    if (rst_i || flush_i) m_rem = '0;
    else begin
      if ((m_rem != 0) && issue_ready_i) m_rem = m_rem & ~m_grp;
      if (fetch_valid_i && exp_frdy) begin
        for (int k = 0; k < W; k++) m_inst[k] = fetch_inst_i[32*k +: 32];
        m_pc  = fetch_pc_i;
        m_rem = fetch_mask_i;
      end
    end
    m_grp = model_group(m_rem);
    @(negedge clk_i);
  endtask

  task automatic offer(input logic [31:0] i0, i1, i2, i3, input logic [W-1:0] mask);
    fetch_inst_i  = {i3, i2, i1, i0};
    fetch_pc_i    = 32'h0000_1000 + {$urandom_range(0, 255), 4'h0};
    fetch_mask_i  = mask;
    fetch_valid_i = 1'b1;
    step();
    fetch_valid_i = 1'b0;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [4:0] a, b, c;
    a = 5'($urandom_range(0, 3)); b = 5'($urandom_range(0, 3)); c = 5'($urandom_range(0, 3));
    case ($urandom_range(0, 12))
      0:  return {12'd5, b, 3'b000, a, 7'b0010011};
      1:  return {7'd0, c, b, 3'b000, a, 7'b0110011};
      2:  return {12'd8, b, 3'b010, a, 7'b0000011};
      3:  return {7'd0, c, b, 3'b010, 5'd4, 7'b0100011};
      4:  return {7'd1, c, b, 3'b000, a, 7'b0110011};
      5:  return {7'd1, c, b, 3'b100, a, 7'b0110011};
      6:  return {7'd0, c, b, 3'b000, 5'd0, 7'b1100011};
      7:  return {20'd0, a, 7'b1101111};
      8:  return {20'h12345, a, 7'b0110111};
      9:  return {12'h300, b, 3'b001, a, 7'b1110011};
      10: return 32'h00000073;
      11: return 32'h0FF0000F;
      default: return 32'hFFFFFFFF;
    endcase
  endfunction

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; fetch_valid_i = 1'b0; issue_ready_i = 1'b1;
    fetch_inst_i = '0; fetch_pc_i = '0; fetch_mask_i = '0;
    m_rem = '0; m_grp = '0; m_pc = '0;
    for (int k = 0; k < W; k++) m_inst[k] = '0;
    @(negedge clk_i);
    #1;
    chk("rst_inst", issue_inst_o[63:0], 64'd0);
    chk("rst_pc", issue_pc_o[127:64], 64'd0);
    chk("rst_class", issue_class_o, 28'd0);
    chk("rst_illegal", issue_illegal_o, 4'd0);
    chk("rst_mask", issue_mask_o, 4'd0);
    @(negedge clk_i);
    step();
    rst_i = 1'b0;
    step();
    chk("rdy_after_rst", last_frdy, 1'b1);

    // RAW split
    offer(32'h00100093, 32'h00108133, 32'h0, 32'h0, 4'b0011);
    step(); chk("t1_g0", last_mask, 4'b0001);
    step(); chk("t1_g1", last_mask, 4'b0010);
    // dual lsu split, then independent pair
    offer(32'h00002183, 32'h00302223, 32'h0, 32'h0, 4'b0011);
    step(); chk("t2_lsu_g0", last_mask, 4'b0001);
    step(); chk("t2_lsu_g1", last_mask, 4'b0010);
    offer(32'h00100093, 32'h00200213, 32'h0, 32'h0, 4'b0011);
    step(); chk("t2_pair", last_mask, 4'b0011);
    // csr issues alone; ready only on the last fire
    offer(32'h00000073, 32'h00100093, 32'h0, 32'h0, 4'b0011);
    step(); chk("t3_g0", last_mask, 4'b0001); chk("t3_rdy0", last_frdy, 1'b0);
    step(); chk("t3_g1", last_mask, 4'b0010); chk("t3_rdy1", last_frdy, 1'b1);
    // stall then flush
    issue_ready_i = 1'b0;
    offer(32'h00100093, 32'h00108133, 32'h0, 32'h0, 4'b0011);
    for (int n = 0; n < 3; n++) begin step(); chk("t4_stall", last_mask, 4'b0001); end
    flush_i = 1'b1; step(); flush_i = 1'b0;
    step(); chk("t4_flush_mask", last_mask, 4'b0000); chk("t4_flush_rdy", last_frdy, 1'b1);
    issue_ready_i = 1'b1;
    // unknown encoding
    offer(32'hFFFFFFFF, 32'h00100093, 32'h0, 32'h0, 4'b0011);
    step();
    if (TRAP) begin
      chk("t5_g0", last_mask, 4'b0001);
      step(); chk("t5_g1", last_mask, 4'b0010);
    end else begin
      chk("t5_pair", last_mask, 4'b0011);
    end
    step();
    // holes and mul RAW
    offer(32'h00100093, 32'h021082b3, 32'h0, 32'h00300313, 4'b1011);
    step(); chk("t6_g0", last_mask, 4'b0001);
    step(); chk("t6_g1", last_mask, 4'b1010);
    // empty mask dropped
    offer(32'h00100093, 32'h0, 32'h0, 32'h0, 4'b0000);
    step(); chk("t7_empty", last_mask, 4'b0000);
    // reset mid-bundle
    issue_ready_i = 1'b0;
    offer(32'h00100093, 32'h00108133, 32'h0, 32'h0, 4'b0011);
    step();
    rst_i = 1'b1; step(); rst_i = 1'b0;
    step(); chk("rst_mid", last_mask, 4'b0000);

    for (int n = 0; n < 600; n++) begin
      fetch_valid_i = ($urandom_range(0, 9) < 7);
      fetch_inst_i  = {rand_inst(), rand_inst(), rand_inst(), rand_inst()};
      fetch_pc_i    = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      fetch_mask_i  = 4'($urandom_range(0, 15));
      issue_ready_i = ($urandom_range(0, 3) != 0);
      flush_i       = ($urandom_range(0, 19) == 0);
      step();
    end
    fetch_valid_i = 1'b0; flush_i = 1'b0; issue_ready_i = 1'b1;
    for (int n = 0; n < 6; n++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
